ones_pattern_gen: RTL

- Producer side of the popcount checker: given a requested ones-count K, builds a WIDTH-bit word containing exactly K set bits.
- The set bits are contiguous, starting at a rotating offset and wrapping around.
- The word is built one bit per cycle by a control FSM and a datapath register.
- The result is presented on a valid/ready output, so it can drive the checker's Input or a scoreboard directly.

---
 rtl/ones_pattern_if.sv | 38 +++
 rtl/ones_pattern_gen.sv | 95 +++++++++
 2 files changed

// File: rtl/ones_pattern_if.sv
// Request/response bundle for ones_pattern_gen; master is the generator side.
// Out_Parity exists only when ONES_PATTERN_PARITY_EN is defined.
interface ones_pattern_if #(
    parameter int WIDTH = 8
);
    localparam int CW = $clog2(WIDTH + 1);
    localparam int OW = $clog2(WIDTH);

    logic             start;
    logic [CW-1:0]    Count_In;
    logic [OW-1:0]    Offset;
    logic [WIDTH-1:0] Out_Data;
    logic             Out_Valid;
    logic             Out_Ready;
    logic             busy;
    logic             err;
`ifdef ONES_PATTERN_PARITY_EN
    logic             Out_Parity;

    modport master (
        input  start, Count_In, Offset, Out_Ready,
        output Out_Data, Out_Valid, busy, err, Out_Parity
    );
    modport slave (
        output start, Count_In, Offset, Out_Ready,
        input  Out_Data, Out_Valid, busy, err, Out_Parity
    );
`else
    modport master (
        input  start, Count_In, Offset, Out_Ready,
        output Out_Data, Out_Valid, busy, err
    );
    modport slave (
        output start, Count_In, Offset, Out_Ready,
        input  Out_Data, Out_Valid, busy, err
    );
`endif
endinterface

// File: rtl/ones_pattern_gen.sv
// Builds a WIDTH-bit word with K contiguous set bits starting at Offset (wrapping),
// one bit per cycle, and offers it on a valid/ready port. Optional ONES_PATTERN_PARITY_EN adds Out_Parity.
module ones_pattern_gen #(
    parameter int WIDTH = 8
) (
    input  logic          clk,
    input  logic          rst,
    ones_pattern_if.master bus
);
    localparam int CW = $clog2(WIDTH + 1);
    localparam int OW = $clog2(WIDTH);

    typedef enum logic [1:0] {IDLE, SHIFT, VALID} state_t;

    state_t           state;
    logic [OW-1:0]    idx;
    logic [CW-1:0]    k_q;
    logic [OW-1:0]    off_q;
    logic [WIDTH-1:0] data_q;
    logic             valid_q;
    logic             busy_q;
    logic             err_q;
    logic             parity_q;
    logic [OW-1:0]    pos;
    logic             bit_val;

    // Position wraps naturally at OW bits, which is mod WIDTH for a power-of-two WIDTH.
    assign pos     = off_q + idx;
    assign bit_val = CW'(idx) < k_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            idx      <= '0;
            k_q      <= '0;
            off_q    <= '0;
            data_q   <= '0;
            valid_q  <= 1'b0;
            busy_q   <= 1'b0;
            err_q    <= 1'b0;
            parity_q <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        data_q   <= '0;
                        parity_q <= 1'b0;
                        busy_q   <= 1'b1;
                        // Legality is judged on the full CW-bit count, before any use as an index.
                        if (bus.Count_In > CW'(WIDTH)) begin
                            err_q   <= 1'b1;
                            valid_q <= 1'b1;
                            state   <= VALID;
                        end else begin
                            err_q <= 1'b0;
                            k_q   <= bus.Count_In;
                            off_q <= bus.Offset;
                            idx   <= '0;
                            state <= SHIFT;
                        end
                    end
                end
                SHIFT: begin
                    data_q[pos] <= bit_val;
                    parity_q    <= parity_q ^ bit_val;
                    idx         <= idx + OW'(1);
                    if (idx == OW'(WIDTH - 1)) begin
                        valid_q <= 1'b1;
                        state   <= VALID;
                    end
                end
                VALID: begin
                    if (bus.Out_Ready) begin
                        valid_q <= 1'b0;
                        busy_q  <= 1'b0;
                        state   <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.Out_Data  = data_q;
    assign bus.Out_Valid = valid_q;
    assign bus.busy      = busy_q;
    assign bus.err       = err_q;
`ifdef ONES_PATTERN_PARITY_EN
    // The running parity stays 0 on an illegal request since no bits are shifted in.
    assign bus.Out_Parity = parity_q;
`else
    logic unused_parity;
    assign unused_parity = parity_q;
`endif
endmodule
